// File: rtl/cmp_pkg.sv
// cmp_pkg: compare op codes shared by the branch decoder and the compare queue
package cmp_pkg;
    localparam int CMP_OP_W = 4;
    localparam logic [CMP_OP_W-1:0] CMP_EQ  = 4'd0;
    localparam logic [CMP_OP_W-1:0] CMP_GT  = 4'd1;
    localparam logic [CMP_OP_W-1:0] CMP_LT  = 4'd2;
    localparam logic [CMP_OP_W-1:0] CMP_NE  = 4'd3;
    localparam logic [CMP_OP_W-1:0] CMP_GE  = 4'd4;
    localparam logic [CMP_OP_W-1:0] CMP_LE  = 4'd5;
    localparam logic [CMP_OP_W-1:0] CMP_EQZ = 4'd6;
    localparam logic [CMP_OP_W-1:0] CMP_GTZ = 4'd7;
    localparam logic [CMP_OP_W-1:0] CMP_LTZ = 4'd8;
    localparam logic [CMP_OP_W-1:0] CMP_NEZ = 4'd9;
    localparam logic [CMP_OP_W-1:0] CMP_GEZ = 4'd10;
    localparam logic [CMP_OP_W-1:0] CMP_LEZ = 4'd11;
endpackage

// File: rtl/cmp_core.sv
// cmp_core: combinational branch compare; zero tests are always signed
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [CMP_OP_W-1:0] op,
    input  logic                sgn,
    output logic                taken,
    output logic                err
);
    logic eq, lt, gt, a_zero, a_neg;
    assign eq     = a == b;
    assign lt     = sgn ? ($signed(a) < $signed(b)) : (a < b);
    assign gt     = sgn ? ($signed(a) > $signed(b)) : (a > b);
    assign a_zero = a == '0;
    assign a_neg  = a[WIDTH-1];
    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        case (op)
            CMP_EQ:  taken = eq;
            CMP_GT:  taken = gt;
            CMP_LT:  taken = lt;
            CMP_NE:  taken = !eq;
            CMP_GE:  taken = !lt;
            CMP_LE:  taken = !gt;
            CMP_EQZ: taken = a_zero;
            CMP_GTZ: taken = !a_neg && !a_zero;
            CMP_LTZ: taken = a_neg;
            CMP_NEZ: taken = !a_zero;
            CMP_GEZ: taken = !a_neg;
            CMP_LEZ: taken = a_neg || a_zero;
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_cmp_queue.sv
// branch_cmp_queue: registered branch compare feeding a DEPTH-entry result FIFO
// with flush and a saturating taken counter
module branch_cmp_queue
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [CMP_OP_W-1:0] in_op,
    input  logic                in_signed,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_taken,
    output logic                out_err,
    output logic [TAG_W-1:0]    out_tag,
    input  logic                flush,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    taken_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic [DEPTH-1:0] taken_q, err_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic             c_taken, c_err, push, pop;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a(in_a), .b(in_b), .op(in_op), .sgn(in_signed), .taken(c_taken), .err(c_err)
    );

    assign in_ready  = count < FULL;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_taken = taken_q[rptr];
    assign out_err   = err_q[rptr];
    assign out_tag   = tag_q[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            taken_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                taken_q[wptr] <= c_taken;
                err_q[wptr]   <= c_err;
                tag_q[wptr]   <= in_tag;
                wptr          <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // illegal ops never count as taken even though their taken bit is already 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) taken_cnt <= '0;
        else if (cnt_clr) taken_cnt <= '0;
        else if (pop && out_taken && !out_err && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
    end
endmodule

// File: tb/tb_branch_cmp_queue.sv
// tb_branch_cmp_queue: vector table, corner sequences and random traffic
// checked against a queue-based reference model
module tb_branch_cmp_queue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_signed = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_tag = '0, out_tag;
    logic        out_valid, out_ready = 1'b0, out_taken, out_err;
    logic        flush = 1'b0, cnt_clr = 1'b0;
    logic [1:0]  taken_cnt;

    branch_cmp_queue #(.WIDTH(32), .DEPTH(2), .TAG_W(5), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_err(out_err), .out_tag(out_tag), .flush(flush), .cnt_clr(cnt_clr),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit t; bit e; logic [4:0] tag; } ent_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; bit s; bit t; bit e; } vec_t;

    ent_t       q[$];
    logic [4:0] popped[$];
    int         mcnt = 0;
    int         checks = 0, errors = 0;
    vec_t       vecs[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // {taken, err} from the op-code rules using wide integer arithmetic
    function automatic logic [1:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input bit s);
        longint x, y;
        bit t;
        if (op > 4'd11) return 2'b01;
        if (op >= 4'd6) begin
            x = longint'($signed(a));
            y = 0;
        end else if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        case (int'(op) % 6)
            0: t = x == y;
            1: t = x > y;
            2: t = x < y;
            3: t = x != y;
            4: t = x >= y;
            default: t = x <= y;
        endcase
        return {t, 1'b0};
    endfunction

    task automatic step();
        bit push, pop;
        ent_t e;
        logic [1:0] r;
        push = in_valid && q.size() < 2;
        pop  = out_ready && q.size() > 0;
        if (pop && !flush) popped.push_back(out_tag);
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (pop) begin
                e = q.pop_front();
                if (e.t && !e.e && mcnt < 3) mcnt++;
            end
            if (push) begin
                r = model(in_a, in_b, in_op, in_signed);
                q.push_back('{r[1], r[0], in_tag});
            end
        end
        if (cnt_clr) mcnt = 0;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("taken_cnt", 32'(taken_cnt), 32'(mcnt));
        if (q.size() > 0) begin
            chk("out_taken", 32'(out_taken), 32'(q[0].t));
            chk("out_err", 32'(out_err), 32'(q[0].e));
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input bit s, input logic [4:0] tag);
        in_a = a; in_b = b; in_op = op; in_signed = s; in_tag = tag;
    endtask

    initial begin
        int saved;
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 4'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 4'd1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd0, 32'd7, 4'd8, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'd0, 32'd7, 4'd11, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'd0, 4'd10, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'd5, 32'd5, 4'd13, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'd5, 32'd5, 4'd0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32'd5, 32'd5, 4'd3, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h80000000, 32'd0, 4'd2, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'd0, 4'd2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'd3, 32'd3, 4'd4, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd1, 32'hFFFFFFFF, 4'd5, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32'd0, 32'd9, 4'd6, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd1, 32'd9, 4'd7, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'd0, 32'd9, 4'd9, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h80000000, 32'd0, 4'd7, 1'b0, 1'b0, 1'b0});

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_taken", 32'(out_taken), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        #5 reset_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, 5'(i));
            in_valid = 1'b1; out_ready = 1'b0;
            step();
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_taken", 32'(out_taken), 32'(vecs[i].t));
            chk("vec_err", 32'(out_err), 32'(vecs[i].e));
            in_valid = 1'b0; out_ready = 1'b1;
            saved = mcnt;
            step();
            if (vecs[i].e) chk("err_cnt_hold", 32'(taken_cnt), 32'(saved));
        end

        // back-pressure: tag 3 must be held until a slot frees
        out_ready = 1'b0; popped.delete();
        for (int t = 1; t <= 3; t++) begin
            drive(32'd1, 32'd1, 4'd0, 1'b0, 5'(t));
            in_valid = 1'b1;
            step();
            if (t == 2) chk("full_in_ready", 32'(in_ready), 32'd0);
        end
        drive(32'd1, 32'd1, 4'd0, 1'b0, 5'd3);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        chk("fifo_pop_cnt", 32'(popped.size()), 32'd3);
        for (int i = 0; i < popped.size() && i < 3; i++) chk("fifo_order", 32'(popped[i]), 32'(i + 1));

        // flush with a same-cycle pop and push
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'd0, 32'd0, 4'd0, 1'b0, 5'd9);
        step(); step();
        saved = mcnt;
        flush = 1'b1; out_ready = 1'b1;
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_cnt", 32'(taken_cnt), 32'(saved));
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_empty", 32'(out_valid), 32'd0);

        // saturation and clear priority
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (6) step();
        chk("sat_cnt", 32'(taken_cnt), 32'd3);
        cnt_clr = 1'b1;
        step();
        chk("clr_prio", 32'(taken_cnt), 32'd0);
        cnt_clr = 1'b0; in_valid = 1'b0;
        step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            in_a = ($urandom_range(0, 3) == 0) ? 32'(1 << $urandom_range(0, 31)) - 32'($urandom_range(0, 1)) : $urandom;
            if ($urandom_range(0, 5) == 0) in_a = '0;
            in_b = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
            in_op = 4'($urandom_range(0, 15));
            in_signed = 1'($urandom);
            in_tag = 5'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            cnt_clr = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0; cnt_clr = 1'b0;

        // asynchronous reset between edges
        cnt_clr = 1'b1; in_valid = 1'b0; step(); cnt_clr = 1'b0;
        drive(32'd2, 32'd2, 4'd0, 1'b0, 5'd7);
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        chk("pre_rst_cnt", 32'(taken_cnt), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        q.delete(); mcnt = 0;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt", 32'(taken_cnt), 32'd0);
        chk("arst_tag", 32'(out_tag), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        #8 reset_n = 1'b1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("arst_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
